// File: rtl/fht_io_ctrl.sv
// fht_io_ctrl: loads N samples into the 4 FHT bank RAMs, kicks the FHT controller, then streams the results out.
// Define FHT_IO_BITREV_EN to scatter incoming samples to bit-reversed positions; otherwise they are written in arrival order.
module fht_io_ctrl #(
    parameter int A_BIT = 8,
    parameter int N_BIT = A_BIT + 2,
    parameter int D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    output logic [D_BIT-1:0] oWR_DATA,
    output logic [A_BIT-1:0] oWR_ADDR,
    output logic [3:0]       oWE,
    output logic             oSTART,
    input  logic             iFHT_RDY,
    output logic [A_BIT-1:0] oRD_ADDR,
    output logic [1:0]       oRD_BANK,
    input  logic [D_BIT-1:0] iRD_DATA,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY
);
    typedef enum logic [2:0] {
        LOAD      = 3'd0,
        KICK      = 3'd1,
        BUSY_WAIT = 3'd2,
        RUN       = 3'd3,
        UNLOAD    = 3'd4
    } state_t;

    localparam logic [N_BIT-1:0] CNT_ONE  = {{(N_BIT-1){1'b0}}, 1'b1};
    localparam logic [N_BIT-1:0] CNT_LAST = {N_BIT{1'b1}};

    function automatic logic [N_BIT-1:0] bitrev(input logic [N_BIT-1:0] v);
        logic [N_BIT-1:0] r;
        for (int i = 0; i < N_BIT; i++) begin
            r[i] = v[N_BIT-1-i];
        end
        return r;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [N_BIT-1:0] n_r, m_r, out_cnt_r, widx_s;
    logic             ready_r, start_r, rd_done_r, inflight_r;
    logic [3:0]       we_r;
    logic [A_BIT-1:0] wr_addr_r;
    logic [D_BIT-1:0] wr_data_r;
    logic [D_BIT-1:0] fifo_r [2];
    logic             wr_ptr_r, rd_ptr_r;
    logic [1:0]       occ_r;
    logic [2:0]       level_s;
    logic             accept_s, pop_s, push_s, issue_s, last_in_s, last_out_s;

    // Handshake decode and read-issue decision
    always_comb begin
        accept_s   = 1'b0;
        widx_s     = '0;
        pop_s      = 1'b0;
        push_s     = 1'b0;
        level_s    = 3'd0;
        issue_s    = 1'b0;
        last_in_s  = 1'b0;
        last_out_s = 1'b0;
        accept_s   = (state_r == LOAD) && iVALID && ready_r;
`ifdef FHT_IO_BITREV_EN
        widx_s     = bitrev(n_r);
`else
        widx_s     = n_r;
`endif
        pop_s      = (occ_r != 2'd0) && iREADY;
        push_s     = inflight_r;
        // Reads in flight are counted as occupied so a 2-deep FIFO never overflows yet sustains 1/cycle.
        level_s    = {1'b0, occ_r} - {2'b00, pop_s} + {2'b00, inflight_r};
        issue_s    = (state_r == UNLOAD) && !rd_done_r && (level_s < 3'd2);
        last_in_s  = accept_s && (n_r == CNT_LAST);
        last_out_s = (state_r == UNLOAD) && pop_s && (out_cnt_r == CNT_LAST);
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (last_in_s) state_nxt_s = KICK;
                else           state_nxt_s = LOAD;
            end
            KICK: state_nxt_s = BUSY_WAIT;
            BUSY_WAIT: begin
                // rdy is still high for a cycle after the start pulse; only a low rdy means the run began.
                if (!iFHT_RDY) state_nxt_s = RUN;
                else           state_nxt_s = BUSY_WAIT;
            end
            RUN: begin
                if (iFHT_RDY) state_nxt_s = UNLOAD;
                else          state_nxt_s = RUN;
            end
            UNLOAD: begin
                if (last_out_s) state_nxt_s = LOAD;
                else            state_nxt_s = UNLOAD;
            end
            default: state_nxt_s = LOAD;
        endcase
    end

    // State register
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) state_r <= LOAD;
        else         state_r <= state_nxt_s;
    end

    // Load side: sample counter, input ready and single-cycle bank write
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            n_r       <= '0;
            ready_r   <= 1'b1;
            we_r      <= 4'b0000;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            start_r   <= 1'b0;
        end else begin
            start_r <= (state_r == KICK);
            if (accept_s) begin
                n_r       <= n_r + CNT_ONE;
                we_r      <= 4'b0001 << widx_s[N_BIT-1:A_BIT];
                wr_addr_r <= widx_s[A_BIT-1:0];
                wr_data_r <= iDATA;
            end else begin
                we_r <= 4'b0000;
            end
            if (last_in_s)       ready_r <= 1'b0;
            else if (last_out_s) ready_r <= 1'b1;
            else                 ready_r <= ready_r;
        end
    end

    // Unload side: natural-order read counter and output transfer counter
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            m_r        <= '0;
            rd_done_r  <= 1'b0;
            inflight_r <= 1'b0;
            out_cnt_r  <= '0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                m_r       <= m_r + CNT_ONE;
                rd_done_r <= (m_r == CNT_LAST);
            end else if (last_out_s) begin
                rd_done_r <= 1'b0;
            end else begin
                rd_done_r <= rd_done_r;
            end
            if (last_out_s)  out_cnt_r <= '0;
            else if (pop_s)  out_cnt_r <= out_cnt_r + CNT_ONE;
            else             out_cnt_r <= out_cnt_r;
        end
    end

    // Two-entry output FIFO fed by the bank read data
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            fifo_r[0] <= '0;
            fifo_r[1] <= '0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            occ_r     <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= iRD_DATA;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= ~rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign oREADY   = ready_r;
    assign oWE      = we_r;
    assign oWR_ADDR = wr_addr_r;
    assign oWR_DATA = wr_data_r;
    assign oSTART   = start_r;
    assign oRD_BANK = m_r[N_BIT-1:A_BIT];
    assign oRD_ADDR = m_r[A_BIT-1:0];
    assign oDATA    = fifo_r[rd_ptr_r];
    assign oVALID   = (occ_r != 2'd0);

endmodule
